// File: rtl/eg2000_joy_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the EG2000 analog joystick path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eg2000_joy_pkg;

    localparam int POS_W = 6;
    localparam logic [POS_W-1:0] CENTRE_X = 6'd32;
    localparam logic [POS_W-1:0] CENTRE_Y = 6'd31;
    localparam logic [POS_W-1:0] DPAD_MID = 6'd31;
    localparam logic [POS_W-1:0] POS_MIN  = 6'd0;
    localparam logic [POS_W-1:0] POS_MAX  = 6'd63;

    typedef enum logic {
        ST_RUN,
        ST_CAL_PEND
    } cal_state_e;

    // Clamp a 9-bit signed difference back into the 8-bit stick range.
    function automatic logic signed [7:0] sat8(input logic signed [8:0] d);
        if (d > 9'sd127) begin
            return 8'sh7f;
        end else if (d < -9'sd128) begin
            return 8'sh80;
        end else begin
            return d[7:0];
        end
    endfunction

    // Map signed -128..127 onto 0..63: (v + 128) >> 2, the +128 being a sign-bit flip.
    function automatic logic [POS_W-1:0] axis_map(input logic signed [7:0] v);
        logic [7:0] biased;
        biased = v ^ 8'h80;
        return biased[7:2];
    endfunction

endpackage

// File: rtl/eg2000_joy_analog_if.sv
// Stick inputs and conditioned X/Y position outputs of one joystick conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; valid_o is a fire-and-forget update strobe.
interface eg2000_joy_analog_if;

    logic [15:0]                     joya_i;
    logic [3:0]                      joy_i;
    logic                            dpad_i;
    logic                            cal_i;
    logic [eg2000_joy_pkg::POS_W-1:0] pos_x_o;
    logic [eg2000_joy_pkg::POS_W-1:0] pos_y_o;
    logic                            valid_o;

    modport slave (
        input  joya_i, joy_i, dpad_i, cal_i,
        output pos_x_o, pos_y_o, valid_o
    );

    modport master (
        output joya_i, joy_i, dpad_i, cal_i,
        input  pos_x_o, pos_y_o, valid_o
    );

endinterface

// File: rtl/eg2000_joy_axis.sv
// One stick axis: accumulate, average, offset (EG2000_JOY_CAL_EN), deadzone, map to 0..63.
// Latency: position register loads on the stage-1 cycle, visible 2 clocks after the last sample.
// Backpressure: none; digital load has priority, analog load is gated by the top.
module eg2000_joy_axis
    import eg2000_joy_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DEADZONE = 2,
    parameter bit INVERT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       sample_i,
    input  logic             tick_i,
    input  logic             clr_i,
    input  logic             s1_i,
    input  logic             load_i,
`ifdef EG2000_JOY_CAL_EN
    input  logic             cal_cap_i,
`endif
    input  logic             dig_en_i,
    input  logic [POS_W-1:0] dig_pos_i,
    output logic [POS_W-1:0] pos_o
);

    localparam int ACC_W = 8 + AVG_LOG2;
    localparam logic signed [9:0] DZ = 10'(DEADZONE);
    localparam logic [POS_W-1:0] POS_RST = INVERT ? CENTRE_Y : CENTRE_X;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic signed [7:0]       avg, offset, v_sat, v_dz, v_fin;
    logic signed [8:0]       diff;
    logic signed [9:0]       v_ext;
    logic [POS_W-1:0]        m, pos_an;

    // Averaging, offset removal, deadzone and mapping for the stage-1 cycle.
    always_comb begin
        avg    = 8'(acc_q >>> AVG_LOG2);
        diff   = 9'(avg) - 9'(offset);
        v_sat  = sat8(diff);
        v_ext  = 10'(v_sat);
        v_dz   = ((v_ext <= DZ) && (v_ext >= -DZ)) ? 8'sd0 : v_sat;
        m      = axis_map(v_fin);
        pos_an = INVERT ? (POS_MAX - m) : m;
    end

`ifdef EG2000_JOY_CAL_EN
    logic signed [7:0] offset_q, offset_d;

    // The calibration window's average becomes the new centre; its own output is forced to centre.
    always_comb begin
        offset_d = offset_q;
        if (load_i && cal_cap_i) begin
            offset_d = avg;
        end
    end

    // Offset register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign offset = offset_q;
    assign v_fin  = cal_cap_i ? 8'sd0 : v_dz;
`else
    assign offset = '0;
    assign v_fin  = v_dz;
`endif

    // Accumulator clears on a mode restart or once stage 1 has consumed it; ticks add a sample.
    // Stage 1 never coincides with a tick because the prescaler period is at least 2.
    always_comb begin
        acc_d = acc_q;
        if (clr_i || s1_i) begin
            acc_d = '0;
        end
        if (tick_i && !clr_i) begin
            acc_d = acc_d + ACC_W'($signed(sample_i));
        end
    end

    // Output position: digital mode overrides, otherwise update on an accepted analog window.
    always_comb begin
        pos_d = pos_q;
        if (dig_en_i) begin
            pos_d = dig_pos_i;
        end else if (load_i) begin
            pos_d = pos_an;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            pos_q <= POS_RST;
        end else begin
            acc_q <= acc_d;
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/eg2000_joy_analog.sv
// Per-player analog joystick conditioner; calibration FSM/offsets exist only with EG2000_JOY_CAL_EN.
// Latency: analog 2 clocks after the last sample of a window; digital d-pad 1 clock.
// Backpressure: none; valid_o pulses one cycle per analog update, never in digital mode.
module eg2000_joy_analog
    import eg2000_joy_pkg::*;
#(
    parameter int DIV      = 1024,
    parameter int AVG_LOG2 = 2,
    parameter int DEADZONE = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    eg2000_joy_analog_if.slave   bus
);

    localparam int PW = $clog2(DIV);
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'((1 << AVG_LOG2) - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             valid_q, valid_d;
    logic             dpad_prev_q;
    logic             restart, tick, win_end, load, cal_cap;
    logic [POS_W-1:0] dig_x, dig_y;

    // Leaving digital mode restarts the window; a pending stage 1 from the digital era is dropped.
    always_comb begin
        restart = dpad_prev_q && !bus.dpad_i;
        tick    = (presc_q == PRESC_MAX) && !restart;
        win_end = tick && (cnt_q == CNT_MAX);
        load    = s1_q && !bus.dpad_i && !restart;
        dig_x   = bus.joy_i[1] ? POS_MIN : (bus.joy_i[0] ? POS_MAX : DPAD_MID);
        dig_y   = bus.joy_i[2] ? POS_MIN : (bus.joy_i[3] ? POS_MAX : DPAD_MID);
    end

    // Prescaler, sample counter, stage-1 marker and update strobe.
    always_comb begin
        presc_d = (restart || tick) ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (restart || win_end) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        s1_d    = win_end;
        valid_d = load;
    end

    // Sequencing registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            s1_q        <= 1'b0;
            valid_q     <= 1'b0;
            dpad_prev_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            valid_q     <= valid_d;
            dpad_prev_q <= bus.dpad_i;
        end
    end

`ifdef EG2000_JOY_CAL_EN
    cal_state_e state_q, state_d;

    // A cal request arms CAL_PEND; the next accepted analog window is consumed as the centre.
    always_comb begin
        state_d = state_q;
        cal_cap = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.cal_i) begin
                    state_d = ST_CAL_PEND;
                end
            end
            ST_CAL_PEND: begin
                cal_cap = load;
                if (load) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Calibration state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign cal_cap = 1'b0;
`endif

    eg2000_joy_axis #(.AVG_LOG2(AVG_LOG2), .DEADZONE(DEADZONE), .INVERT(1'b0)) u_axis_x (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_i  (bus.joya_i[7:0]),
        .tick_i    (tick),
        .clr_i     (restart),
        .s1_i      (s1_q),
        .load_i    (load),
`ifdef EG2000_JOY_CAL_EN
        .cal_cap_i (cal_cap),
`endif
        .dig_en_i  (bus.dpad_i),
        .dig_pos_i (dig_x),
        .pos_o     (bus.pos_x_o)
    );

    eg2000_joy_axis #(.AVG_LOG2(AVG_LOG2), .DEADZONE(DEADZONE), .INVERT(1'b1)) u_axis_y (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_i  (bus.joya_i[15:8]),
        .tick_i    (tick),
        .clr_i     (restart),
        .s1_i      (s1_q),
        .load_i    (load),
`ifdef EG2000_JOY_CAL_EN
        .cal_cap_i (cal_cap),
`endif
        .dig_en_i  (bus.dpad_i),
        .dig_pos_i (dig_y),
        .pos_o     (bus.pos_y_o)
    );

    assign bus.valid_o = valid_q;

`ifndef EG2000_JOY_CAL_EN
    logic unused_cal;
    assign unused_cal = bus.cal_i | cal_cap;
`endif

endmodule

// File: doc/eg2000_joy_analog.md
Name: eg2000_joy_analog

Overview:
Analog joystick conditioner for one player of the EG2000 parallel-port joystick path. Samples the MiSTer signed analog stick at a fixed prescaled rate, block-averages, removes a calibration offset, applies a deadzone and maps each axis to the 6-bit position (0..63) that the joystick/keypad port stage compares against the PSG port-A select value. A digital d-pad override is also provided. Instantiated twice, once per player; its outputs feed the joystick/keypad port stage's X/Y position inputs directly.

Parameters:
DIV, 1024, clocks per sample tick (>=2)
AVG_LOG2, 2, log2 of samples per averaging window (0..4)
DEADZONE, 2, |axis| <= DEADZONE (after offset) forced to 0

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
joya_i  in  16  analog stick; [7:0] X signed, [15:8] Y signed (negative = up)
joy_i  in  4  digital dirs: [0] right, [1] left, [2] down, [3] up
dpad_i  in  1  1 = digital mode, 0 = analog mode
cal_i  in  1  one-cycle pulse: capture centre offset from next window
pos_x_o  out  6  X position 0..63
pos_y_o  out  6  Y position 0..63 (inverted)
valid_o  out  1  one-cycle pulse when analog position updates

Behaviour:
- Reset (async assert, sync release): pos_x_o=32, pos_y_o=31, valid_o=0; prescaler, sample count, accumulators, offsets=0; state RUN.
- Prescaler counts 0..DIV-1; tick on DIV-1, then wraps to 0.
- Each tick: acc_x += sext(joya_i[7:0]), acc_y likewise; accumulators are signed, 8+AVG_LOG2 bits, and cannot overflow. Sample count wraps at 2^AVG_LOG2.
- Window end (tick at which the count wraps), cycle T: the clock edge ending T registers the sample into the accumulator.
- Cycle T+1 (stage 1): avg = acc>>>AVG_LOG2 (arithmetic); v = sat8(avg - offset), saturating to -128..127; if |v| <= DEADZONE then v=0. Accumulators clear.
- Cycle T+2 (stage 2): map m = (v+128)>>2. pos_x_o=m, pos_y_o=63-m, valid_o=1 for exactly one cycle. Total latency from final sample = 2 clocks.
- FSM RUN/CAL_PEND:
  - cal_i in RUN moves to CAL_PEND.
  - At the next stage-1 in CAL_PEND: offset_x/y <= avg_x/y, v forced 0 (outputs 32/31), return to RUN.
  - cal_i in CAL_PEND is ignored.
  - cal_i in the same cycle as a window end: that window is the calibration window.
- Digital mode (dpad_i=1): outputs registered every clock, 1-cycle latency, valid_o held 0.
  - X: left->0, else right->63, else 31.
  - Y: down->0, else up->63, else 31.
  - Left and right both set gives left priority; down and up both set gives down priority.
  - Accumulation keeps running; stage-2 results are discarded.
- dpad_i 1->0: prescaler, count and accumulators clear. Outputs hold the last digital values until the first complete analog window.
- dpad_i 0->1: takes effect on the next edge. A pending CAL_PEND is held until analog mode resumes.
- Reset mid-window or mid-pipeline: all partial state discarded, no valid_o pulse.

Optional Feature:
EG2000_JOY_CAL_EN
- Defined: offset registers and the RUN/CAL_PEND FSM exist as described.
- Undefined: offsets are constant 0, cal_i is ignored (port retained, unconnected internally), no FSM.

Decomposition:
- Package eg2000_joy_pkg:
  - POS_W=6, CENTRE_X=6'd32, CENTRE_Y=6'd31, DPAD_MID=6'd31
  - function sat8 (signed 9->8 saturate)
  - function axis_map (signed 8 -> 6-bit)
- Sub-module eg2000_joy_axis: one axis; holds accumulator, offset, deadzone, stage-1/2 registers; parameter INVERT. Instantiated twice (X INVERT=0, Y INVERT=1).
- Top level owns the prescaler, sample count, FSM, digital mux and valid_o.

Test Plan:
(All tests use DIV=4, AVG_LOG2=2, DEADZONE=2.)
1. Reset: assert reset_n=0 mid-window -> pos_x_o=32, pos_y_o=31, valid_o=0 immediately; no valid_o pulse until 16 clocks after release.
2. Range extremes: joya_i=16'h807F held -> after the first window, pos_x_o=63, pos_y_o=63, valid_o high exactly 1 cycle, 2 clocks after the 4th tick.
3. Averaging: X samples 0,0,0,100 -> avg 25 -> pos_x_o=38. Deadzone: X=+2 -> 32; X=-2 -> 32; X=+8 -> 34.
4. Digital: dpad_i=1, joy_i=4'b0011 -> pos_x_o=0; 4'b1100 -> pos_y_o=0; 4'b0000 -> 31/31. All with 1-clock latency and valid_o=0.
5. Calibration (EG2000_JOY_CAL_EN defined): X=+20 held, pulse cal_i -> next window pos_x_o=32, later windows 32. X=-128 -> v saturates -128 -> pos_x_o=0. Without the macro: X=+20 -> pos_x_o=37.
6. Mode switch: dpad 1->0 mid-window -> outputs hold the digital values; the first valid_o fires exactly 16 clocks plus 2 of latency after the switch.
